// File: rtl/sr_ff_state_monitor.sv
// SR flip-flop q/qb monitor: samples the pair, filters glitches, tracks the accepted
// state and counts transitions. Optional macro XZ_DETECT_EN maps X/Z samples to INVALID.
module sr_ff_state_monitor #(
   parameter int CNT_W      = 8,
   parameter int STABLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             q,
   input  logic             qb,
   output logic [1:0]       state,
   output logic             state_valid,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic             illegal
);

   localparam int STAB_W = $clog2(STABLE_CYC + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);

   localparam logic [1:0] ST_UNKNOWN = 2'b00;
   localparam logic [1:0] ST_RESET   = 2'b01;
   localparam logic [1:0] ST_SET     = 2'b10;
   localparam logic [1:0] ST_INVALID = 2'b11;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic              q_s_q, q_s_d;
   logic              qb_s_q, qb_s_d;
   logic              smp_vld_q, smp_vld_d;
   logic [1:0]        cls_q, cls_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [1:0]        state_q, state_d;
   logic              state_valid_q, state_valid_d;
   logic [CNT_W-1:0]  rise_q, rise_d;
   logic [CNT_W-1:0]  fall_q, fall_d;
   logic [CNT_W-1:0]  ill_cnt_q, ill_cnt_d;
   logic              illegal_q, illegal_d;
   logic [1:0]        cls_s;
   logic              accept_s;
   logic [CNT_W-1:0]  rise_inc_s, fall_inc_s, ill_inc_s;
   logic              illegal_set_s;

   // Classify the registered pair
   always_comb begin
      cls_s = ST_INVALID;
`ifdef XZ_DETECT_EN
      if ((^{q_s_q, qb_s_q}) === 1'bx) begin
         cls_s = ST_INVALID;
      end else begin
         case ({q_s_q, qb_s_q})
            2'b10:   cls_s = ST_SET;
            2'b01:   cls_s = ST_RESET;
            default: cls_s = ST_INVALID;
         endcase
      end
`else
      case ({q_s_q, qb_s_q})
         2'b10:   cls_s = ST_SET;
         2'b01:   cls_s = ST_RESET;
         default: cls_s = ST_INVALID;
      endcase
`endif
   end

   // Sampling, stability filter and acceptance; smp_vld keeps the reset-value sample out of the filter
   always_comb begin
      q_s_d     = q_s_q;
      qb_s_d    = qb_s_q;
      smp_vld_d = smp_vld_q;
      cls_d     = cls_q;
      stab_d    = stab_q;
      accept_s  = 1'b0;
      if (en) begin
         q_s_d     = q;
         qb_s_d    = qb;
         smp_vld_d = 1'b1;
         if (smp_vld_q) begin
            cls_d = cls_s;
            if (cls_s == cls_q) begin
               if (stab_q == STAB_MAX) begin
                  stab_d = STAB_MAX;
               end else begin
                  stab_d = stab_q + STAB_W'(1);
               end
            end else begin
               stab_d = STAB_W'(1);
            end
            accept_s = (stab_d == STAB_MAX) && (cls_s != state_q);
         end else begin
            cls_d = cls_q;
         end
      end else begin
         accept_s = 1'b0;
      end
   end

   // State FSM and event counters; clr overrides any same-edge increment
   always_comb begin
      state_d       = state_q;
      state_valid_d = state_valid_q;
      rise_inc_s    = rise_q;
      fall_inc_s    = fall_q;
      ill_inc_s     = ill_cnt_q;
      illegal_set_s = illegal_q;
      if (accept_s) begin
         state_d       = cls_s;
         state_valid_d = 1'b1;
         case (cls_s)
            ST_INVALID: begin
               ill_inc_s     = sat_inc(ill_cnt_q);
               illegal_set_s = 1'b1;
            end
            ST_SET: begin
               if (state_q == ST_RESET) begin
                  rise_inc_s = sat_inc(rise_q);
               end else begin
                  rise_inc_s = rise_q;
               end
            end
            ST_RESET: begin
               if (state_q == ST_SET) begin
                  fall_inc_s = sat_inc(fall_q);
               end else begin
                  fall_inc_s = fall_q;
               end
            end
            default: state_d = ST_UNKNOWN;
         endcase
      end else begin
         state_d = state_q;
      end
      rise_d    = clr ? {CNT_W{1'b0}} : rise_inc_s;
      fall_d    = clr ? {CNT_W{1'b0}} : fall_inc_s;
      ill_cnt_d = clr ? {CNT_W{1'b0}} : ill_inc_s;
      illegal_d = clr ? 1'b0 : illegal_set_s;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_s_q         <= 1'b0;
         qb_s_q        <= 1'b0;
         smp_vld_q     <= 1'b0;
         cls_q         <= 2'b00;
         stab_q        <= {STAB_W{1'b0}};
         state_q       <= ST_UNKNOWN;
         state_valid_q <= 1'b0;
         rise_q        <= {CNT_W{1'b0}};
         fall_q        <= {CNT_W{1'b0}};
         ill_cnt_q     <= {CNT_W{1'b0}};
         illegal_q     <= 1'b0;
      end else begin
         q_s_q         <= q_s_d;
         qb_s_q        <= qb_s_d;
         smp_vld_q     <= smp_vld_d;
         cls_q         <= cls_d;
         stab_q        <= stab_d;
         state_q       <= state_d;
         state_valid_q <= state_valid_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         ill_cnt_q     <= ill_cnt_d;
         illegal_q     <= illegal_d;
      end
   end

   assign state       = state_q;
   assign state_valid = state_valid_q;
   assign rise_cnt    = rise_q;
   assign fall_cnt    = fall_q;
   assign illegal_cnt = ill_cnt_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_sr_ff_state_monitor.sv
// Directed bench for sr_ff_state_monitor: default instance plus a CNT_W=2, STABLE_CYC=1
// instance for saturation, single-cycle latency and clr priority.
module tb_sr_ff_state_monitor;

   logic       clk = 1'b0;
   logic       rst_n, en, clr, q, qb;
   logic       en2, clr2, q2, qb2;
   logic [1:0] state, state2;
   logic       state_valid, state_valid2, illegal, illegal2;
   logic [7:0] rise_cnt, fall_cnt, illegal_cnt;
   logic [1:0] rise2, fall2, illc2;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   sr_ff_state_monitor dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q(q), .qb(qb),
      .state(state), .state_valid(state_valid), .rise_cnt(rise_cnt),
      .fall_cnt(fall_cnt), .illegal_cnt(illegal_cnt), .illegal(illegal)
   );

   sr_ff_state_monitor #(.CNT_W(2), .STABLE_CYC(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .q(q2), .qb(qb2),
      .state(state2), .state_valid(state_valid2), .rise_cnt(rise2),
      .fall_cnt(fall2), .illegal_cnt(illc2), .illegal(illegal2)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [1:0] st, input logic sv,
                           input logic [7:0] r, input logic [7:0] f,
                           input logic [7:0] ic, input logic il);
      chk({tag, "_state"}, {30'd0, state}, {30'd0, st});
      chk({tag, "_valid"}, {31'd0, state_valid}, {31'd0, sv});
      chk({tag, "_rise"}, {24'd0, rise_cnt}, {24'd0, r});
      chk({tag, "_fall"}, {24'd0, fall_cnt}, {24'd0, f});
      chk({tag, "_illc"}, {24'd0, illegal_cnt}, {24'd0, ic});
      chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, il});
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; q = 1'bx; qb = 1'bx;
      en2 = 1'b0; clr2 = 1'b0; q2 = 1'b0; qb2 = 1'b0;
      tick(2);
      chk_main("reset", 2'b00, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      chk("reset2_state", {30'd0, state2}, 32'd0);

      // RESET accepted two samples after the sampling edge
      rst_n = 1'b1; en = 1'b1; q = 1'b0; qb = 1'b1;
      tick(2);
      chk("lat_pending", {30'd0, state}, 32'd0);
      tick(1);
      chk_main("acc_reset", 2'b01, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);

      q = 1'b1; qb = 1'b0;
      tick(3);
      chk_main("rise1", 2'b10, 1'b1, 8'd1, 8'd0, 8'd0, 1'b0);
      q = 1'b0; qb = 1'b1;
      tick(3);
      chk_main("fall1", 2'b01, 1'b1, 8'd1, 8'd1, 8'd0, 1'b0);
      q = 1'b1; qb = 1'b0;
      tick(3);
      chk_main("rise2", 2'b10, 1'b1, 8'd2, 8'd1, 8'd0, 1'b0);

      // One-sample RESET glitch is filtered
      q = 1'b0; qb = 1'b1;
      tick(1);
      q = 1'b1; qb = 1'b0;
      tick(4);
      chk_main("glitch", 2'b10, 1'b1, 8'd2, 8'd1, 8'd0, 1'b0);

      // 11 pair enters INVALID, then back to SET without counting a rise
      q = 1'b1; qb = 1'b1;
      tick(2);
      chk("inv_pending", {30'd0, state}, 32'd2);
      tick(1);
      chk_main("invalid", 2'b11, 1'b1, 8'd2, 8'd1, 8'd1, 1'b1);
      q = 1'b1; qb = 1'b0;
      tick(3);
      chk_main("inv_exit", 2'b10, 1'b1, 8'd2, 8'd1, 8'd1, 1'b1);

      // en=0 freezes everything while inputs toggle
      en = 1'b0;
      q = 1'b0; qb = 1'b1; tick(3);
      q = 1'b0; qb = 1'b0; tick(3);
      chk_main("frozen", 2'b10, 1'b1, 8'd2, 8'd1, 8'd1, 1'b1);

      // clr with en=0 zeroes counters only
      clr = 1'b1; tick(1); clr = 1'b0;
      chk_main("clr", 2'b10, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);

      // Mid-operation reset
      rst_n = 1'b0; tick(1); rst_n = 1'b1;
      chk_main("midrst", 2'b00, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

      // Second instance: one-sample latency and saturation
      en2 = 1'b1; q2 = 1'b0; qb2 = 1'b1;
      tick(1);
      chk("s1_pending", {30'd0, state2}, 32'd0);
      tick(1);
      chk("s1_reset", {30'd0, state2}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         q2 = 1'b1; qb2 = 1'b0; tick(2);
         q2 = 1'b0; qb2 = 1'b1; tick(2);
      end
      chk("sat_rise", {30'd0, rise2}, 32'd3);
      chk("sat_fall", {30'd0, fall2}, 32'd3);
      q2 = 1'b1; qb2 = 1'b1; tick(2);
      chk("s2_invalid", {30'd0, state2}, 32'd3);
      chk("s2_illegal", {31'd0, illegal2}, 32'd1);
      chk("s2_illc", {30'd0, illc2}, 32'd1);
      q2 = 1'b0; qb2 = 1'b1; tick(2);
      chk("s2_back_reset", {30'd0, state2}, 32'd1);
      q2 = 1'b1; qb2 = 1'b0; tick(1);
      clr2 = 1'b1; tick(1); clr2 = 1'b0;
      chk("clr_win_rise", {30'd0, rise2}, 32'd0);
      chk("clr_win_illegal", {31'd0, illegal2}, 32'd0);
      chk("clr_win_fall", {30'd0, fall2}, 32'd0);
      chk("clr_keep_state", {30'd0, state2}, 32'd2);
      chk("clr_keep_valid", {31'd0, state_valid2}, 32'd1);

`ifdef XZ_DETECT_EN
      en = 1'b1; q = 1'bz; qb = 1'bz;
      tick(3);
      chk("xz_state", {30'd0, state}, 32'd3);
      chk("xz_illegal", {31'd0, illegal}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
